answer_generator: RTL
=====================

ANSWER_GENERATOR -- requirements
Module: answer_generator

Interface
REQ-001 The block SHALL have one parameter: LFSR_INIT, default 16'hACE1, the non-zero LFSR value loaded at reset.
REQ-002 clock  input  1  the single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  level from the start button; only its rising edge SHALL request a new answer.
REQ-005 busy  output  1  high while a draw is in progress.
REQ-006 ans_valid  output  1  high while ans0..ans3 hold a complete, legal answer.
REQ-007 ans0, ans1, ans2, ans3  output  4 each  secret answer digits (BCD); ans0 is the rightmost digit and ans3 the leftmost.

Function
REQ-008 A 16-bit Fibonacci LFSR with taps 16,14,13,11 SHALL advance on every clock in every state, so the answer depends on when the player presses start.
REQ-009 Edge detection SHALL use a registered copy start_d; start_pulse = start & ~start_d.
REQ-010 The FSM SHALL have three states: IDLE, DRAW and CHECK.
REQ-011 In IDLE, start_pulse SHALL perform all of the following, then move to DRAW:
- clear digit index idx to 0;
- set busy;
- clear ans_valid.
REQ-012 In DRAW, the candidate cand SHALL be lfsr[3:0].
- cand > 9: reject it and stay in DRAW.
- cand <= 9: register it and move to CHECK.
REQ-013 In CHECK, cand SHALL be compared against the accepted digits 0..idx-1.
- Any match: return to DRAW.
- No match: write cand to scratch slot idx.
- If idx == 3: go to IDLE.
- Otherwise: increment idx and go to DRAW.
REQ-014 Scratch slots SHALL copy to ans0..ans3 in the same cycle that the fourth digit is accepted; ans_valid SHALL then rise and busy SHALL fall.
- The ans outputs SHALL never show a partial answer.
- During a draw the ans outputs SHALL hold the previous answer.
REQ-015 The four answer digits SHALL be pairwise distinct, each 0..9; a leading zero (ans3 = 0) is legal.
REQ-016 Minimum latency: ans_valid SHALL be high 9 cycles after the edge where start is first sampled high. The draw has no upper bound; rejection sampling on a maximal-length LFSR guarantees progress.
REQ-017 A start_pulse while busy is high SHALL be ignored and SHALL NOT restart the draw.
REQ-018 ans_valid SHALL stay high in IDLE until the next accepted start_pulse or rst.
REQ-019 Holding start high SHALL produce exactly one draw.
REQ-020 The LFSR SHALL never reach the all-zero state.

Reset
REQ-021 When rst is high at a clock edge, the block SHALL, regardless of state:
- enter IDLE;
- load lfsr with LFSR_INIT;
- clear start_d, idx and the scratch slots;
- drive busy=0, ans_valid=0 and ans0..ans3=0.
REQ-022 rst SHALL take priority over start_pulse in the same cycle; a draw in progress SHALL be abandoned with no answer published.

Configuration
REQ-023 With macro FIXED_ANSWER_EN defined, the LFSR and DRAW/CHECK path SHALL be bypassed.
- start_pulse SHALL set busy for 1 cycle.
- It SHALL then publish ans3..ans0 = 1,2,3,4 with ans_valid high 2 cycles after start is sampled.
REQ-024 With FIXED_ANSWER_EN undefined, the random behaviour of REQ-008..REQ-020 SHALL apply; the port list SHALL be identical in both builds.

Verification
REQ-025 Reset: rst=1 for 2 cycles mid-draw -> busy=0, ans_valid=0, ans0..ans3=0 one cycle later; lfsr=16'hACE1.
REQ-026 Single draw: start held high 20 cycles -> exactly one rise of ans_valid, no earlier than 9 cycles after start; digits all <=9 and pairwise distinct; digits match a bit-accurate model seeded with 16'hACE1.
REQ-027 Busy ignore: second start pulse 3 cycles into a draw -> one completion only, at the same cycle as without the second pulse.
REQ-028 Reset mid-operation: rst at cycle 4 of a draw, then start -> previous ans values are not published; the new draw completes legally.
REQ-029 Soak: 1000 back-to-back draws -> every answer legal and matching the model; ans0..ans3 stable whenever busy=1; a leading-zero answer occurs at least once.
REQ-030 FIXED_ANSWER_EN build: start pulse -> busy for 1 cycle, then ans3..ans0 = 1,2,3,4 and ans_valid=1 exactly 2 cycles after start.

Source files
------------

// File: rtl/answer_generator.sv
// Secret-answer generator: draws four distinct BCD digits by rejection-sampling a 16-bit LFSR.
// Define FIXED_ANSWER_EN to bypass the random draw and always publish 1,2,3,4 after one busy cycle.
module answer_generator #(
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       ans_valid,
  output logic [3:0] ans0,
  output logic [3:0] ans1,
  output logic [3:0] ans2,
  output logic [3:0] ans3
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            start_d;
  logic            start_pulse;
  logic            busy_nxt;
  logic            valid_nxt;
  logic [3:0][3:0] ans_q;
  logic [3:0][3:0] ans_nxt;

  assign start_pulse = start & ~start_d;

  assign ans0 = ans_q[0];
  assign ans1 = ans_q[1];
  assign ans2 = ans_q[2];
  assign ans3 = ans_q[3];

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      busy      <= 1'b0;
      ans_valid <= 1'b0;
      ans_q     <= '0;
    end else begin
      state     <= state_nxt;
      start_d   <= start;
      busy      <= busy_nxt;
      ans_valid <= valid_nxt;
      ans_q     <= ans_nxt;
    end
  end

`ifdef FIXED_ANSWER_EN

  // DRAW doubles as the single busy cycle before the constant answer is published.
  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    valid_nxt = ans_valid;
    ans_nxt   = ans_q;
    case (state)
      IDLE: begin
        if (start_pulse) begin
          busy_nxt  = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        ans_nxt   = {4'd1, 4'd2, 4'd3, 4'd4};
        valid_nxt = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

`else

  logic [15:0]     lfsr;
  logic [1:0]      idx;
  logic [1:0]      idx_nxt;
  logic [3:0]      cand;
  logic [3:0]      cand_nxt;
  logic [3:0][3:0] slot;
  logic [3:0][3:0] slot_nxt;

  // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length, never reaches zero).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic is_dup(input logic [3:0] c, input logic [3:0][3:0] s,
                                  input logic [1:0] n);
    is_dup = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ((2'(i) < n) && (s[i] == c)) is_dup = 1'b1;
    end
  endfunction

  // The LFSR free-runs in every state so the answer depends on when start is pressed.
  always_ff @(posedge clock) begin
    if (rst) begin
      lfsr <= LFSR_INIT;
      idx  <= 2'd0;
      cand <= 4'd0;
      slot <= '0;
    end else begin
      lfsr <= lfsr_step(lfsr);
      idx  <= idx_nxt;
      cand <= cand_nxt;
      slot <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    valid_nxt = ans_valid;
    ans_nxt   = ans_q;
    idx_nxt   = idx;
    cand_nxt  = cand;
    slot_nxt  = slot;
    case (state)
      IDLE: begin
        if (start_pulse) begin
          idx_nxt   = 2'd0;
          busy_nxt  = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        if (lfsr[3:0] <= 4'd9) begin
          cand_nxt  = lfsr[3:0];
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (is_dup(cand, slot, idx)) begin
          state_nxt = DRAW;
        end else begin
          slot_nxt[idx] = cand;
          if (idx == 2'd3) begin
            // Publish all four digits at once so the outputs never show a partial answer.
            ans_nxt   = slot_nxt;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = DRAW;
          end
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

`endif

endmodule
